// File: rtl/gate_bist.sv
// gate_bist: exhaustive self-test of a 2-input gate against a programmable truth table.
// Reports a saturating mismatch count, the first failing {b,a} pattern, and pass/fail.
module gate_bist #(
    parameter int LOOPS = 1,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       tt,
    output logic             a,
    output logic             b,
    input  logic             o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [1:0]       first_fail
);
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [LW-1:0] LAST_LOOP = LW'(LOOPS - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state, state_d;
    logic [3:0]    tt_q;
    logic [1:0]    idx, nidx;
    logic [LW-1:0] loop;
    logic          mis, last;

    always_comb begin
        mis     = o != tt_q[idx];
        last    = (idx == 2'd3) && (loop == LAST_LOOP);
        nidx    = idx + 2'd1;
        state_d = (state == IDLE)   ? (start ? DRIVE : IDLE) :
                  (state == DRIVE)  ? SAMPLE :
                  (state == SAMPLE) ? (last ? DONE : DRIVE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q       <= '0;
            idx        <= '0;
            loop       <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                tt_q       <= tt;
                idx        <= '0;
                loop       <= '0;
                a          <= 1'b0;
                b          <= 1'b0;
                busy       <= 1'b1;
                pass       <= 1'b0;
                err_cnt    <= '0;
                fail_valid <= 1'b0;
                first_fail <= '0;
            end else if (state == SAMPLE) begin
                if (mis) begin
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                    if (!fail_valid) begin
                        first_fail <= idx;
                        fail_valid <= 1'b1;
                    end
                end
                if (last) begin
                    a    <= 1'b0;
                    b    <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= !(mis || fail_valid);
                end else begin
                    idx <= nidx;
                    if (idx == 2'd3) loop <= loop + LW'(1);
                    a <= nidx[0];
                    b <= nidx[1];
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: two BIST instances (LOOPS=1 and LOOPS=8) driving a modelled gate
// described by its own truth table; results checked against a pattern-count model.
module tb_gate_bist;
    logic       clk = 1'b0;
    logic [1:0] rst_n_v = 2'b00;
    logic [1:0] start_v = 2'b00;
    logic [3:0] tt_v   [2];
    logic [3:0] gate_v [2];
    logic [1:0] o_v, a_v, b_v, busy_v, done_v, pass_v, fv_v;
    logic [3:0] err_v  [2];
    logic [1:0] ff_v   [2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign o_v[0] = gate_v[0][{b_v[0], a_v[0]}];
    assign o_v[1] = gate_v[1][{b_v[1], a_v[1]}];

    gate_bist #(.LOOPS(1), .ERR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .tt(tt_v[0]),
        .a(a_v[0]), .b(b_v[0]), .o(o_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_cnt(err_v[0]), .fail_valid(fv_v[0]), .first_fail(ff_v[0])
    );

    gate_bist #(.LOOPS(8), .ERR_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .tt(tt_v[1]),
        .a(a_v[1]), .b(b_v[1]), .o(o_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_cnt(err_v[1]), .fail_valid(fv_v[1]), .first_fail(ff_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_rst(input int k);
        chk("rst_ab", {b_v[k], a_v[k]}, 0);
        chk("rst_busy", busy_v[k], 0);
        chk("rst_done", done_v[k], 0);
        chk("rst_pass", pass_v[k], 0);
        chk("rst_err", err_v[k], 0);
        chk("rst_fv", fv_v[k], 0);
        chk("rst_ff", ff_v[k], 0);
    endtask

    // pre: the start edge has already happened (held-start relaunch)
    task automatic run(input int k, input logic [3:0] t, input logic [3:0] g,
                       input bit glitch, input bit hold, input bit pre);
        int loops, mm, ff, tot;
        loops = (k != 0) ? 8 : 1;
        mm = 0;
        ff = -1;
        for (int p = 0; p < 4; p++)
            if (t[p] != g[p]) begin
                mm++;
                if (ff < 0) ff = p;
            end
        tot = mm * loops;
        gate_v[k] = g;
        if (!pre) begin
            tt_v[k] = t;
            start_v[k] = 1'b1;
            @(posedge clk);
            #1 start_v[k] = 1'b0;
        end
        tt_v[k] = 4'($urandom);
        for (int e = 0; e < 8 * loops; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (glitch && e == 3) start_v[k] = 1'b1;
            if (glitch && e == 4) start_v[k] = 1'b0;
            chk("ab_seq", {b_v[k], a_v[k]}, (e / 2) % 4);
            chk("busy_run", busy_v[k], 1);
            chk("done_early", done_v[k], 0);
        end
        @(posedge clk);
        #1;
        if (hold) start_v[k] = 1'b1;
        chk("done_pulse", done_v[k], 1);
        chk("busy_end", busy_v[k], 0);
        chk("ab_end", {b_v[k], a_v[k]}, 0);
        chk("pass", pass_v[k], tot == 0);
        chk("err_cnt", err_v[k], (tot > 15) ? 15 : tot);
        chk("fail_valid", fv_v[k], tot > 0);
        chk("first_fail", ff_v[k], (ff < 0) ? 0 : ff);
        @(posedge clk);
        #1;
        if (hold) tt_v[k] = t;
        chk("done_clear", done_v[k], 0);
        chk("busy_idle", busy_v[k], 0);
        chk("pass_hold", pass_v[k], tot == 0);
        chk("err_hold", err_v[k], (tot > 15) ? 15 : tot);
        if (hold) begin
            @(posedge clk);
            #1 start_v[k] = 1'b0;
            chk("relaunch_busy", busy_v[k], 1);
            chk("relaunch_err", err_v[k], 0);
            chk("relaunch_fv", fv_v[k], 0);
            chk("relaunch_pass", pass_v[k], 0);
            chk("relaunch_ff", ff_v[k], 0);
        end
    endtask

    initial begin
        tt_v[0] = 4'b0; tt_v[1] = 4'b0;
        gate_v[0] = 4'b1110; gate_v[1] = 4'b1110;
        #2;
        chk_rst(0);
        chk_rst(1);
        @(negedge clk);
        rst_n_v = 2'b11;
        @(negedge clk);
        run(0, 4'b1110, 4'b1110, 0, 0, 0);
        run(0, 4'b1110, 4'b0000, 0, 0, 0);
        run(0, 4'b0110, 4'b1110, 0, 0, 0);
        run(1, 4'b1110, 4'b0001, 0, 0, 0);
        run(1, 4'b1110, 4'b1110, 0, 0, 0);
        run(0, 4'b1110, 4'b0000, 1, 1, 0);
        run(0, 4'b1110, 4'b1110, 0, 0, 1);
        @(negedge clk);
        tt_v[0] = 4'b1110;
        gate_v[0] = 4'b1110;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n_v[0] = 1'b0;
        #1 chk_rst(0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("rst_no_done", done_v[0], 0);
        end
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        @(negedge clk);
        run(0, 4'b1110, 4'b1110, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            run(0, 4'($urandom), 4'($urandom), 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run(1, 4'($urandom), 4'($urandom), 0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
